// File: rtl/exe_hazard_if.sv
// Handshake bundle between the EXE-stage hazard controller and the pipeline registers.
// The controller uses the slave modport; the pipeline or its driver uses the master modport.
interface exe_hazard_if #(
    parameter int REG_BITS = 4,
    parameter int CNT_BITS = 16
);
    logic                id_valid;
    logic [REG_BITS-1:0] id_src1;
    logic [REG_BITS-1:0] id_src2;
    logic                id_two_src;
    logic                exe_wb_en;
    logic [REG_BITS-1:0] exe_dest;
    logic                exe_mem_r_en;
    logic [REG_BITS-1:0] exe_src1;
    logic [REG_BITS-1:0] exe_src2;
    logic                mem_wb_en;
    logic [REG_BITS-1:0] mem_dest;
    logic                mem_access;
    logic                mem_ready;
    logic                wb_wb_en;
    logic [REG_BITS-1:0] wb_dest;
    logic                branch_taken;
    logic                hazard_stall;
    logic                flush;
    logic                freeze;
    logic [1:0]          fwd_sel_a;
    logic [1:0]          fwd_sel_b;
    logic                mem_err;
    logic [CNT_BITS-1:0] stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src,
        output exe_wb_en, exe_dest, exe_mem_r_en, exe_src1, exe_src2,
        output mem_wb_en, mem_dest, mem_access, mem_ready,
        output wb_wb_en, wb_dest, branch_taken,
        input  hazard_stall, flush, freeze, fwd_sel_a, fwd_sel_b, mem_err, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src,
        input  exe_wb_en, exe_dest, exe_mem_r_en, exe_src1, exe_src2,
        input  mem_wb_en, mem_dest, mem_access, mem_ready,
        input  wb_wb_en, wb_dest, branch_taken,
        output hazard_stall, flush, freeze, fwd_sel_a, fwd_sel_b, mem_err, stall_cnt
    );
endinterface

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage pipeline sequencer: RAW stall, branch flush, SRAM freeze with timeout.
// Define HAZARD_FWD_EN to enable operand forwarding (load-use stalls only).
module exe_hazard_ctrl #(
    parameter int REG_BITS    = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_BITS    = 16
) (
    input logic          clk,
    input logic          rst,
    exe_hazard_if.slave  bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic {RUN, MEM_WAIT} state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;
    logic                timeout_hit;
    logic                raw;
    logic                freeze, flush, hazard_stall;

    function automatic logic hit(input logic vld, input logic two,
                                 input logic [REG_BITS-1:0] s1, input logic [REG_BITS-1:0] s2,
                                 input logic [REG_BITS-1:0] x);
        return vld && ((s1 == x) || (two && (s2 == x)));
    endfunction

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src);
        if (bus.mem_wb_en && (bus.mem_dest == src))
            return 2'd1;
        else if (bus.wb_wb_en && (bus.wb_dest == src))
            return 2'd2;
        return 2'd0;
    endfunction

    // Forwarding covers everything except a load whose data is not yet fetched.
    assign raw = bus.exe_wb_en && bus.exe_mem_r_en &&
                 hit(bus.id_valid, bus.id_two_src, bus.id_src1, bus.id_src2, bus.exe_dest);
    assign bus.fwd_sel_a = rst ? fwd_sel(bus.exe_src1) : 2'd0;
    assign bus.fwd_sel_b = rst ? fwd_sel(bus.exe_src2) : 2'd0;
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.exe_mem_r_en, bus.exe_src1, bus.exe_src2, bus.wb_wb_en, bus.wb_dest};
    assign raw = (bus.exe_wb_en &&
                  hit(bus.id_valid, bus.id_two_src, bus.id_src1, bus.id_src2, bus.exe_dest)) ||
                 (bus.mem_wb_en &&
                  hit(bus.id_valid, bus.id_two_src, bus.id_src1, bus.id_src2, bus.mem_dest));
    assign bus.fwd_sel_a = 2'd0;
    assign bus.fwd_sel_b = 2'd0;
`endif

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        timeout_hit = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
        // Outputs are gated by rst so an asserted reset silences them without waiting for a clock.
        freeze       = rst && bus.mem_access && !bus.mem_ready &&
                       !((state_q == MEM_WAIT) && timeout_hit);
        flush        = rst && bus.branch_taken && !freeze;
        hazard_stall = rst && raw && !freeze && !flush;

        unique case (state_q)
            RUN: begin
                if (bus.mem_access && !bus.mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = RUN;
                end else if (timeout_hit) begin
                    state_d   = RUN;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if ((hazard_stall || freeze) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.freeze       = freeze;
    assign bus.flush        = flush;
    assign bus.hazard_stall = hazard_stall;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_exe_hazard_ctrl;
    localparam int REG_BITS = 4;
    localparam int TO       = 64;
    localparam int CNT_BITS = 8;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    exe_hazard_if #(.REG_BITS(REG_BITS), .CNT_BITS(CNT_BITS)) bus ();

    exe_hazard_ctrl #(.REG_BITS(REG_BITS), .MEM_TIMEOUT(TO), .CNT_BITS(CNT_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model state: whether an SRAM wait is outstanding and how long it has lasted.
    bit m_wait;
    int m_age;
    bit m_err;
    int m_cnt;

    bit       e_freeze, e_flush, e_stall;
    bit [1:0] e_fa, e_fb;

    function automatic bit uses(input logic [REG_BITS-1:0] r);
        return bus.id_valid && (bus.id_src1 == r || (bus.id_two_src && bus.id_src2 == r));
    endfunction

    function automatic bit [1:0] fsel(input logic [REG_BITS-1:0] s);
        if (bus.mem_wb_en && bus.mem_dest == s) return 2'd1;
        if (bus.wb_wb_en && bus.wb_dest == s) return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        bit dep;
        dep      = 1'b0;
        e_freeze = 1'b0;
        e_flush  = 1'b0;
        e_stall  = 1'b0;
        e_fa     = 2'd0;
        e_fb     = 2'd0;
`ifdef HAZARD_FWD_EN
        dep = bus.exe_wb_en && bus.exe_mem_r_en && uses(bus.exe_dest);
        if (rst) begin
            e_fa = fsel(bus.exe_src1);
            e_fb = fsel(bus.exe_src2);
        end
`else
        dep = (bus.exe_wb_en && uses(bus.exe_dest)) || (bus.mem_wb_en && uses(bus.mem_dest));
`endif
        if (rst) begin
            e_freeze = bus.mem_access && !bus.mem_ready && !(m_wait && m_age == TO - 1);
            e_flush  = bus.branch_taken && !e_freeze;
            e_stall  = dep && !e_freeze && !e_flush;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wait <= 1'b0;
            m_age  <= 0;
            m_err  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (e_stall || e_freeze) m_cnt <= (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (!m_wait) begin
                if (bus.mem_access && !bus.mem_ready) begin
                    m_wait <= 1'b1;
                    m_age  <= 0;
                end
            end else if (bus.mem_ready) begin
                m_wait <= 1'b0;
            end else if (m_age == TO - 1) begin
                m_wait <= 1'b0;
                m_err  <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_freeze", int'(bus.freeze), int'(e_freeze));
        chk("m_flush", int'(bus.flush), int'(e_flush));
        chk("m_stall", int'(bus.hazard_stall), int'(e_stall));
        chk("m_fwd_a", int'(bus.fwd_sel_a), int'(e_fa));
        chk("m_fwd_b", int'(bus.fwd_sel_b), int'(e_fb));
        chk("m_err", int'(bus.mem_err), int'(m_err));
        chk("m_cnt", int'(bus.stall_cnt), m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_two_src = 0;
        bus.exe_wb_en = 0; bus.exe_dest = 0; bus.exe_mem_r_en = 0;
        bus.exe_src1 = 0; bus.exe_src2 = 0;
        bus.mem_wb_en = 0; bus.mem_dest = 0; bus.mem_access = 0; bus.mem_ready = 1;
        bus.wb_wb_en = 0; bus.wb_dest = 0; bus.branch_taken = 0;
    endtask

    initial begin
        int fcount;
        int burst;
        int cnt0;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_cnt", int'(bus.stall_cnt), 0);
        chk("rst_err", int'(bus.mem_err), 0);
        chk("rst_freeze", int'(bus.freeze), 0);
        step();
        rst = 1'b1;
        step();

        // Dependency on EXE destination r3.
        bus.exe_wb_en = 1; bus.exe_dest = 3; bus.id_src1 = 3; bus.id_valid = 1;
        @(negedge clk);
`ifndef HAZARD_FWD_EN
        chk("t1_stall", int'(bus.hazard_stall), 1);
        step();
        @(negedge clk);
        chk("t1_cnt", int'(bus.stall_cnt), 1);
`else
        chk("t1_stall_fwd", int'(bus.hazard_stall), 0);
`endif
        bus.id_valid = 0;
        #1;
        chk("t1_drop", int'(bus.hazard_stall), 0);
        step();
        idle();

`ifdef HAZARD_FWD_EN
        bus.mem_wb_en = 1; bus.mem_dest = 5; bus.wb_wb_en = 1; bus.wb_dest = 5; bus.exe_src1 = 5;
        #1;
        chk("t2_fwd_mem", int'(bus.fwd_sel_a), 1);
        bus.mem_wb_en = 0;
        #1;
        chk("t2_fwd_wb", int'(bus.fwd_sel_a), 2);
        idle();
        bus.exe_wb_en = 1; bus.exe_mem_r_en = 1; bus.exe_dest = 5;
        bus.id_valid = 1; bus.id_src2 = 5; bus.id_two_src = 1;
        #1;
        chk("t2_loaduse", int'(bus.hazard_stall), 1);
        step();
        idle();
`endif

        // Branch together with a load-use dependency, then also with an SRAM stall.
        bus.exe_wb_en = 1; bus.exe_mem_r_en = 1; bus.exe_dest = 7;
        bus.id_valid = 1; bus.id_src1 = 7; bus.branch_taken = 1;
        #1;
        chk("t3_flush", int'(bus.flush), 1);
        chk("t3_nostall", int'(bus.hazard_stall), 0);
        bus.mem_access = 1; bus.mem_ready = 0;
        #1;
        chk("t3_freeze", int'(bus.freeze), 1);
        chk("t3_noflush", int'(bus.flush), 0);
        step();
        bus.mem_ready = 1;
        step();
        idle();
        step();

        // Three not-ready cycles.
        fcount = 0;
        bus.mem_access = 1; bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.freeze) fcount++;
            step();
        end
        bus.mem_ready = 1;
        @(negedge clk);
        chk("t4_fcount", fcount, 3);
        chk("t4_release", int'(bus.freeze), 0);
        chk("t4_err", int'(bus.mem_err), 0);
        step();
        idle();
        step();

        // Timeout: 64 frozen cycles, one released cycle, then the stuck access stalls again.
        fcount = 0;
        bus.mem_access = 1; bus.mem_ready = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.freeze) fcount++;
            step();
        end
        chk("t5_fcount", fcount, 64);
        @(negedge clk);
        chk("t5_drop", int'(bus.freeze), 0);
        chk("t5_err_pre", int'(bus.mem_err), 0);
        step();
        @(negedge clk);
        chk("t5_err", int'(bus.mem_err), 1);
        chk("t5_refreeze", int'(bus.freeze), 1);
        cnt0 = int'(bus.stall_cnt);
        step();
        @(negedge clk);
        chk("t5_cnt_inc", int'(bus.stall_cnt), cnt0 + 1);
        repeat (300) step();
        @(negedge clk);
        chk("sat_cnt", int'(bus.stall_cnt), CNT_MAX);
        chk("sat_err", int'(bus.mem_err), 1);

        // Asynchronous reset while waiting on SRAM.
        #1;
        rst = 1'b0;
        #1;
        chk("t6_freeze", int'(bus.freeze), 0);
        chk("t6_err", int'(bus.mem_err), 0);
        chk("t6_cnt", int'(bus.stall_cnt), 0);
        step();
        bus.mem_ready = 1;
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("t6_run", int'(bus.freeze), 0);
        step();
        bus.mem_ready = 0;
        #1;
        chk("t6_newwait", int'(bus.freeze), 1);
        step();
        idle();
        step();

        // Randomized traffic; the model check runs every cycle.
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            bus.id_valid     = $urandom_range(0, 3) != 0;
            bus.id_src1      = REG_BITS'($urandom_range(0, 3));
            bus.id_src2      = REG_BITS'($urandom_range(0, 3));
            bus.id_two_src   = $urandom_range(0, 1) != 0;
            bus.exe_wb_en    = $urandom_range(0, 1) != 0;
            bus.exe_dest     = REG_BITS'($urandom_range(0, 3));
            bus.exe_mem_r_en = $urandom_range(0, 2) == 0;
            bus.exe_src1     = REG_BITS'($urandom_range(0, 3));
            bus.exe_src2     = REG_BITS'($urandom_range(0, 3));
            bus.mem_wb_en    = $urandom_range(0, 1) != 0;
            bus.mem_dest     = REG_BITS'($urandom_range(0, 3));
            bus.wb_wb_en     = $urandom_range(0, 1) != 0;
            bus.wb_dest      = REG_BITS'($urandom_range(0, 3));
            bus.branch_taken = $urandom_range(0, 5) == 0;
            if (burst > 0) begin
                bus.mem_access = 1;
                bus.mem_ready  = 0;
                burst--;
            end else begin
                bus.mem_access = $urandom_range(0, 2) == 0;
                bus.mem_ready  = $urandom_range(0, 3) != 0;
                if ($urandom_range(0, 39) == 0) burst = $urandom_range(1, 80);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                #2 rst = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
